// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch queue:
//   - fetch FSM state encoding (FETCH / WAIT / DROP)
//   - instruction field positions used by the optional branch predecoder
//   - helper that recognises an unconditional branch word
// Optional feature macro: IF_BRANCH_PREDECODE_EN (consumed by if_fetch_queue).
// -----------------------------------------------------------------------------
package if_pkg;

  // Opcode of the unconditional PC-relative branch.
  localparam logic [6:0] UNCOND_BR_OPCODE = 7'b1100000;

  // Field positions inside an instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 25;
  localparam int IMM_W   = 16;

  // FETCH : allowed to issue a request at fetch_pc
  // WAIT  : one request outstanding, its response will be enqueued
  // DROP  : one request outstanding, its response is stale and discarded
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // True when the low 32 bits of an instruction hold an unconditional branch.
  function automatic logic is_uncond_branch(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == UNCOND_BR_OPCODE;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_fetch_queue_if
// Bundles every handshake of the fetch stage:
//   imem_req / imem_addr / imem_gnt / imem_rvalid / imem_rdata : instruction memory
//   redirect_valid / redirect_pc                                : restart from execute
//   instr_valid / instr / instr_pc / instr_ready                : toward decode
// Modports:
//   master : the fetch stage (drives requests and the decode stream)
//   slave  : the environment (memory, execute and decode)
// -----------------------------------------------------------------------------
interface if_fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Synchronous FIFO holding {pc, instr} pairs for the fetch stage.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, din       : write one entry (ignored when full or flushing)
//   pop             : drop the head entry (ignored when empty or flushing)
//   flush           : empty the queue; wins over push and pop
//   dout            : head entry, valid whenever count != 0
//   count           : number of stored entries (0..DEPTH)
//   full, empty     : occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_push;
  logic do_pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;

  // Storage carries no reset; the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Head is read directly so a push becomes visible on the next cycle.
  assign dout = mem[rd_ptr_reg];

endmodule

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
// Instruction fetch stage: generates PCs, fetches from instruction memory with
// at most one outstanding request, and queues {pc, instr} pairs for decode.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset (0 = in reset)
//   bus    : if_fetch_queue_if.master
//            imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in,
//            redirect_valid/redirect_pc in,
//            instr_valid/instr/instr_pc out, instr_ready in
// Optional feature macro: IF_BRANCH_PREDECODE_EN
//   defined   : an enqueued unconditional branch steers fetch to
//               req_pc + sext(imm16)
//   undefined : fetch always continues at req_pc + PC_STEP
// -----------------------------------------------------------------------------
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_queue_if.master bus
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;
  // Holds requests off until the first clock edge after reset releases, so
  // imem_req is low throughout reset without gating on the reset pin.
  logic              run_reg;

  logic [ENTRY_W-1:0] fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic              grant;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] next_pc;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // A request is only raised when the response is sure to find a free slot.
  assign bus.imem_req  = run_reg & (state_reg == FETCH) & ~fifo_full & ~bus.redirect_valid;
  assign bus.imem_addr = fetch_pc_reg;
  assign grant         = bus.imem_req & bus.imem_gnt;

  // A response is enqueued only for a live request; a same-cycle redirect
  // turns it stale.
  assign accept = (state_reg == WAIT) & bus.imem_rvalid & ~bus.redirect_valid;

  assign bus.instr_valid = (fifo_count != '0) & ~bus.redirect_valid;
  assign bus.instr       = fifo_dout[INSTR_W-1:0];
  assign bus.instr_pc    = fifo_dout[ENTRY_W-1:INSTR_W];
  assign pop             = bus.instr_valid & bus.instr_ready & ~fifo_empty;

  // ---------------------------------------------------------------------------
  // Next fetch address after an accepted response
  // ---------------------------------------------------------------------------
  assign seq_pc = req_pc_reg + ADDR_W'(PC_STEP);

`ifdef IF_BRANCH_PREDECODE_EN
  logic [ADDR_W-1:0] br_pc;

  // Immediate is a signed byte offset relative to the branch's own address.
  assign br_pc   = req_pc_reg + ADDR_W'(signed'(bus.imem_rdata[IMM_W-1:0]));
  assign next_pc = is_uncond_branch(bus.imem_rdata[31:0]) ? br_pc : seq_pc;
`else
  assign next_pc = seq_pc;
`endif

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ({req_pc_reg, bus.imem_rdata}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Fetch state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      run_reg      <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (bus.redirect_valid) begin
        // Redirect overrides everything. An in-flight request must still
        // drain its single response, which is then thrown away in DROP.
        fetch_pc_reg <= bus.redirect_pc;
        case (state_reg)
          WAIT, DROP: state_reg <= bus.imem_rvalid ? FETCH : DROP;
          default:    state_reg <= FETCH;
        endcase
      end else begin
        case (state_reg)
          FETCH: begin
            if (grant) begin
              req_pc_reg <= fetch_pc_reg;
              state_reg  <= WAIT;
            end
          end
          WAIT: begin
            if (bus.imem_rvalid) begin
              fetch_pc_reg <= next_pc;
              state_reg    <= FETCH;
            end
          end
          DROP: begin
            // fetch_pc already holds the redirect target.
            if (bus.imem_rvalid) begin
              state_reg <= FETCH;
            end
          end
          default: state_reg <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

  if_fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory contents: every word is addr|0x100 except one overridable address.
  logic [31:0] br_addr = 32'hFFFF_FFFF;
  logic [31:0] br_data = 32'h0;

  // Memory model state
  int          lat_min = 0;
  int          lat_max = 0;
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;
  bit          mem_wanted;

  // Reference model: number of instructions owed to decode, next pc decode
  // must see, next address fetch must request.
  int          occ;
  logic [31:0] exp_pc;
  logic [31:0] fetch_exp;
  logic [31:0] pop_log[$];
  logic [31:0] grant_log[$];

  // Last sampled outputs
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == br_addr) return br_data;
    return a | 32'h100;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc);
`ifdef IF_BRANCH_PREDECODE_EN
    logic [31:0] w;
    w = mem_word(pc);
    if (w[31:25] == 7'b1100000) return pc + {{16{w[15]}}, w[15:0]};
`endif
    return pc + 32'd4;
  endfunction

  task automatic drive_idle();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic model_reset();
    mem_busy   = 0;
    mem_wanted = 0;
    mem_delay  = 0;
    mem_addr   = '0;
    occ        = 0;
    exp_pc     = 32'h0;
    fetch_exp  = 32'h0;
    pop_log.delete();
    grant_log.delete();
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: memory responds, decode/execute drive, outputs are
  // checked against the model, then the model advances past the edge.
  task automatic step(input bit rdy, input bit gnt_en, input bit redir, input logic [31:0] rpc);
    bit rv;
    bit gnt_now;
    bit exp_req;
    bit exp_valid;
    @(posedge clk);
    #1;
    rv = 0;
    exp_req = !mem_busy && (occ < DEPTH) && !redir;
    if (mem_busy) begin
      if (mem_delay == 0) rv = 1;
      else mem_delay--;
    end
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? mem_word(mem_addr) : $urandom;
    gnt_now            = gnt_en && !mem_busy;
    bus.imem_gnt       = gnt_now;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.instr_valid;
    s_pc    = bus.instr_pc;
    s_instr = bus.instr;
    exp_valid = (occ != 0) && !redir;

    checks++;
    if (s_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req: got %0b want %0b (occ %0d t=%0t)", s_req, exp_req, occ, $time);
    end
    checks++;
    if (s_valid !== exp_valid) begin
      errors++;
      $display("FAIL instr_valid: got %0b want %0b (occ %0d t=%0t)", s_valid, exp_valid, occ, $time);
    end
    if (exp_req) begin
      checks++;
      if (s_addr !== fetch_exp) begin
        errors++;
        $display("FAIL imem_addr: got %08h want %08h (t=%0t)", s_addr, fetch_exp, $time);
      end
    end
    if (exp_valid) begin
      checks++;
      if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL head: got pc %08h instr %08h want pc %08h instr %08h (t=%0t)",
                 s_pc, s_instr, exp_pc, mem_word(exp_pc), $time);
      end
    end

    // Advance the model across the coming edge.
    if (exp_valid && rdy) begin
      pop_log.push_back(exp_pc);
      exp_pc = model_next(exp_pc);
      occ--;
    end
    if (rv) begin
      if (mem_wanted && !redir) begin
        occ++;
        fetch_exp = model_next(mem_addr);
      end
      mem_busy   = 0;
      mem_wanted = 0;
    end
    if (redir) begin
      occ        = 0;
      exp_pc     = rpc;
      fetch_exp  = rpc;
      mem_wanted = 0;
    end
    if (s_req === 1'b1 && gnt_now) begin
      grant_log.push_back(s_addr);
      mem_busy   = 1;
      mem_wanted = 1;
      mem_addr   = s_addr;
      mem_delay  = int'($urandom_range(lat_max, lat_min));
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    #2;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req %0b valid %0b addr %08h want 0 0 00000000",
               bus.imem_req, bus.instr_valid, bus.imem_addr);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got req %0b valid %0b want 0 0", bus.imem_req, bus.instr_valid);
    end
    reset = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    lat_min = 0; lat_max = 0;
    repeat (9) step(1, 1, 0, 32'h0);
    checks++;
    if (pop_log.size() != 4 || grant_log.size() != 5) begin
      errors++;
      $display("FAIL seq_rate: got pops %0d grants %0d want 4 5", pop_log.size(), grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_log[i] !== 32'(i * 4)) begin
          errors++;
          $display("FAIL seq_pc[%0d]: got %08h want %08h", i, pop_log[i], 32'(i * 4));
        end
      end
    end
    $display("test_sequential pops %0d grants %0d", pop_log.size(), grant_log.size());
  endtask

  task automatic test_stall();
    do_reset();
    lat_min = 0; lat_max = 0;
    repeat (10) step(0, 1, 0, 32'h0);
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0 || grant_log.size() != DEPTH) begin
      errors++;
      $display("FAIL stall_full: got req %0b valid %0b pc %08h grants %0d want 0 1 00000000 %0d",
               s_req, s_valid, s_pc, grant_log.size(), DEPTH);
    end
    repeat (8) step(1, 1, 0, 32'h0);
    checks++;
    if (pop_log.size() < 5) begin
      errors++;
      $display("FAIL stall_release: got pops %0d want >=5", pop_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pop_log[i] !== 32'(i * 4)) begin
          errors++;
          $display("FAIL stall_order[%0d]: got %08h want %08h", i, pop_log[i], 32'(i * 4));
        end
      end
    end
    $display("test_stall pops %0d", pop_log.size());
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1, 1, 0, 32'h0);          // grant at 0, response delayed
    lat_min = 0; lat_max = 0;
    step(1, 1, 1, 32'h200);        // redirect while waiting
    repeat (10) step(1, 1, 0, 32'h0);
    checks++;
    if (grant_log.size() < 2 || pop_log.size() < 1) begin
      errors++;
      $display("FAIL redirect_wait_progress: got grants %0d pops %0d want >=2 >=1",
               grant_log.size(), pop_log.size());
    end else begin
      checks++;
      if (grant_log[1] !== 32'h200 || pop_log[0] !== 32'h200) begin
        errors++;
        $display("FAIL redirect_wait: got addr %08h first pc %08h want 00000200 00000200",
                 grant_log[1], pop_log[0]);
      end
    end
    $display("test_redirect_wait grants %0d pops %0d", grant_log.size(), pop_log.size());
  endtask

  task automatic test_redirect_rvalid_pop();
    do_reset();
    lat_min = 0; lat_max = 0;
    repeat (3) step(0, 1, 0, 32'h0);
    step(1, 1, 1, 32'h300);        // rvalid, valid head and ready all coincide
    checks++;
    if (s_valid !== 1'b0 || pop_log.size() != 0) begin
      errors++;
      $display("FAIL redir_pop: got valid %0b pops %0d want 0 0", s_valid, pop_log.size());
    end
    step(1, 1, 0, 32'h0);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h300) begin
      errors++;
      $display("FAIL redir_after: got valid %0b req %0b addr %08h want 0 1 00000300",
               s_valid, s_req, s_addr);
    end
    repeat (6) step(1, 1, 0, 32'h0);
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h300) begin
      errors++;
      $display("FAIL redir_first: got pops %0d want first 00000300", pop_log.size());
    end
    $display("test_redirect_rvalid_pop pops %0d", pop_log.size());
  endtask

  task automatic test_branch();
    logic [31:0] want;
    logic [31:0] imm_data[2];
    logic [31:0] br_target[2];
    imm_data[0] = 32'hC000FFF0; br_target[0] = 32'h0;
    imm_data[1] = 32'hC0000020; br_target[1] = 32'h30;
    for (int k = 0; k < 2; k++) begin
      br_addr = 32'h10;
      br_data = imm_data[k];
`ifdef IF_BRANCH_PREDECODE_EN
      want = br_target[k];
`else
      want = 32'h14;
`endif
      do_reset();
      lat_min = 0; lat_max = 0;
      repeat (14) step(1, 1, 0, 32'h0);
      checks++;
      if (grant_log.size() < 6 || pop_log.size() < 5) begin
        errors++;
        $display("FAIL branch_progress[%0d]: got grants %0d pops %0d want >=6 >=5",
                 k, grant_log.size(), pop_log.size());
      end else begin
        checks++;
        if (grant_log[5] !== want || pop_log[4] !== 32'h10) begin
          errors++;
          $display("FAIL branch_target[%0d]: got next %08h branch pc %08h want %08h 00000010",
                   k, grant_log[5], pop_log[4], want);
        end
      end
      $display("test_branch case %0d next addr %08h", k, grant_log.size() > 5 ? grant_log[5] : 32'hX);
    end
    br_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_random();
    bit          rdy, gnt, redir;
    logic [31:0] rpc;
    do_reset();
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      gnt   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = 32'($urandom_range(0, 255)) << 2;
      step(rdy, gnt, redir, rpc);
    end
    checks++;
    if (pop_log.size() < 100) begin
      errors++;
      $display("FAIL random_progress: got pops %0d want >=100", pop_log.size());
    end
    $display("test_random pops %0d grants %0d", pop_log.size(), grant_log.size());
  endtask

  task automatic test_async_reset();
    do_reset();
    lat_min = 0; lat_max = 0;
    repeat (4) step(0, 1, 0, 32'h0);
    lat_min = 5; lat_max = 5;
    step(0, 1, 0, 32'h0);          // grant, long response
    step(0, 1, 0, 32'h0);          // waiting
    checks++;
    if (s_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got valid %0b want 1", s_valid);
    end
    #1;
    reset = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL areset_now: got req %0b valid %0b addr %08h want 0 0 00000000",
               bus.imem_req, bus.instr_valid, bus.imem_addr);
    end
    model_reset();
    lat_min = 0; lat_max = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    step(1, 1, 0, 32'h0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_after: got req %0b addr %08h valid %0b want 1 00000000 0",
               s_req, s_addr, s_valid);
    end
    repeat (5) step(1, 1, 0, 32'h0);
    checks++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h0) begin
      errors++;
      $display("FAIL areset_first: got pops %0d want first 00000000", pop_log.size());
    end
    $display("test_async_reset pops %0d", pop_log.size());
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_branch();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
